// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port request/acknowledge arbiter in front of a single-port
// data memory (sync write, combinational read). One access per 3 cycles:
// IDLE (sample/arbitrate) -> ACCESS (drive memory) -> DONE (ack pulse).
// Optional macro DM_ARB_RR_EN selects round-robin tie-breaking; when it is
// undefined, port 0 wins every tie.
module dm_arbiter #(
  parameter int DEPTH = 256,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          dm_W,
  output logic          dm_R,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [1:0]           ack_q, ack_d;
  logic [1:0]           err_q, err_d;
  logic [1:0][DW-1:0]   rdata_q, rdata_d;

  logic [1:0] req;
  logic       win;
  logic       in_range;
  logic       in_access;

  assign req       = {m1_req, m0_req};
  assign in_range  = {1'b0, addr_q} < DEPTH_X;
  assign in_access = (state_q == ACCESS);

  // Winner among current requests (only meaningful when |req).
  always_comb begin
`ifdef DM_ARB_RR_EN
    if (&req) win = ~last_gnt_q;
    else      win = req[1];
`else
    win = ~req[0];
`endif
  end

  // Memory strobes decode from state only so an async reset kills a write
  // before the edge; out-of-range accesses never touch the memory.
  assign dm_W     = in_access & in_range & we_q;
  assign dm_R     = in_access & in_range & ~we_q;
  assign dm_addr  = in_access ? addr_q  : '0;
  assign dm_wdata = in_access ? wdata_q : '0;

  // Next-state and owner/response register updates.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ack_d      = ack_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = ACCESS;
          owner_d    = win;
          last_gnt_d = win;
          we_d       = win ? m1_we    : m0_we;
          addr_d     = win ? m1_addr  : m0_addr;
          wdata_d    = win ? m1_wdata : m0_wdata;
        end
      end
      ACCESS: begin
        state_d          = DONE;
        ack_d[owner_q]   = 1'b1;
        err_d[owner_q]   = ~in_range;
        // dm_rdata is only looked at while dm_R drives the memory.
        rdata_d[owner_q] = dm_R ? dm_rdata : '0;
      end
      DONE: begin
        state_d = IDLE;
        ack_d   = '0;
        err_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign m0_ack   = ack_q[0];
  assign m0_err   = err_q[0];
  assign m0_rdata = rdata_q[0];
  assign m1_ack   = ack_q[1];
  assign m1_err   = err_q[1];
  assign m1_rdata = rdata_q[1];

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-port request/acknowledge arbiter that shares the single-port data memory (word-addressed, sync write, combinational read, tri-stated read data when R=0) between port 0 (CPU load/store unit) and port 1 (debug/DMA loader). It latches one request, drives the memory for exactly one cycle, registers the read data and returns a one-cycle acknowledge. Out-of-range addresses are blocked and reported.

Parameters:
DEPTH, 256, number of memory words; valid word addresses are 0..DEPTH-1
AW, 32, address width of requester and memory ports
DW, 32, data width

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  reset, asynchronous, active-low
m0_req  in  1  port 0 request; held with fields stable until m0_ack
m0_we  in  1  port 0: 1=write, 0=read
m0_addr  in  AW  port 0 word address
m0_wdata  in  DW  port 0 write data
m0_ack  out  1  port 0 one-cycle completion pulse
m0_rdata  out  DW  port 0 read data, valid while m0_ack=1
m0_err  out  1  port 0 address error, valid while m0_ack=1
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err  same as port 0, for port 1
dm_W  out  1  memory write enable
dm_R  out  1  memory read enable
dm_addr  out  AW  memory address
dm_wdata  out  DW  memory write data
dm_rdata  in  DW  memory read data (high-Z when dm_R=0)

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. While rst_n=0: state=IDLE; owner=0; last_gnt=1; latched addr/we/wdata=0; all ack/err=0; all rdata=0; dm_W=dm_R=0; dm_addr=dm_wdata=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req=1 at posedge, pick the winner per the arbitration rule, latch its we/addr/wdata into owner registers, set owner and last_gnt to the winner, go to ACCESS. Otherwise stay in IDLE.
- ACCESS: lasts one cycle. dm_addr and dm_wdata come from the latched registers.
  - In range (addr < DEPTH): dm_W=we and dm_R=!we.
  - Out of range (addr >= DEPTH): dm_W=dm_R=0.
  - dm_W and dm_R are decoded combinationally from state only, so reset asserted during ACCESS drops dm_W before the edge and no write commits.
  - At the posedge: for an in-range read, capture dm_rdata into the owner's rdata; otherwise set that rdata to 0. Set the owner's ack=1, set its err=1 if out of range. Go to DONE.
- DONE: lasts one cycle. ack/err/rdata of the owner are visible. At the posedge, clear ack and err and go to IDLE. rdata holds its value until the next access by the same port.
- Outside ACCESS, dm_W=dm_R=0 and dm_addr=dm_wdata=0. dm_rdata is never sampled when dm_R=0.
- Latency: request sampled at edge E0; memory access during cycle E0-E1; write commits at E1; ack is high during E1-E2. One access every 3 cycles maximum.
- A requester must deassert req in its ack cycle. If req is still high at the DONE->IDLE edge, it is sampled again in IDLE and treated as a new request.
- Requests arriving during ACCESS or DONE wait; they are not lost as long as req is held.
- The non-owner port's ack, err and rdata never change during another port's transaction.
- All arithmetic is unsigned. The range check compares the full AW-bit address against DEPTH.

Optional Feature:
DM_ARB_RR_EN:
- Defined: round-robin arbitration. When both ports request in IDLE, the port not equal to last_gnt wins. With last_gnt=1 after reset, port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins ties; last_gnt is still maintained but unused.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 5 -> dm_W=1 with dm_addr=5 for exactly one cycle; m0_ack pulses 2 cycles after req sampled; m0_err=0.
- m0 reads addr 5 -> m0_rdata=0xDEADBEEF with m0_ack=1; dm_R=1 only in ACCESS; m1 outputs unchanged.
- m0 writes addr 256 (DEPTH=256) -> dm_W never asserts; m0_ack=1, m0_err=1, m0_rdata=0; a read of addr 0 afterwards is unaffected.
- Both ports hold req continuously for 4 transactions -> with DM_ARB_RR_EN grants are 0,1,0,1; without it, all grants go to port 0 while m0_req is held.
- m1 write to addr 7 in progress, rst_n=0 asserted mid-ACCESS -> dm_W drops immediately, all outputs return to reset values, and a later read of addr 7 returns its old value.
- m1_req still high in its DONE cycle -> second access starts 1 cycle after DONE (IDLE re-sample) and m1_ack pulses again.
